// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between ROM and decode
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     rom_req,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic                     rom_ack,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     dec_valid,
    output logic [DATA_W-1:0]        dec_data,
    output logic [ADDR_W-1:0]        dec_pc,
    input  logic                     dec_ready,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              rom_req_q, rom_req_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic              ack_fire;
    logic              pop;
    logic              push;
    logic              flush;
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W-1:0]  count_after;

    // A response only counts while our request is actually outstanding
    assign ack_fire    = rom_req_q & rom_ack;
    assign pop         = dec_valid & dec_ready;
    assign pc_next     = fetch_pc_q + ADDR_W'(PC_STEP);
    assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

    assign rom_req   = rom_req_q;
    assign rom_addr  = rom_addr_q;
    assign count     = count_q;
    assign dec_valid = (count_q != '0);
    assign dec_data  = dec_valid ? data_mem_q[head_q] : '0;
    assign dec_pc    = dec_valid ? pc_mem_q[head_q]   : '0;

    // Fetch FSM: issue requests with a reserved slot, drop stale responses
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                    rom_req_d  = 1'b1;
                    rom_addr_d = redirect_pc;
                    state_d    = S_BUSY;
                end else if (count_q < CNT_W'(DEPTH)) begin
                    rom_req_d  = 1'b1;
                    rom_addr_d = fetch_pc_q;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                    if (ack_fire) begin
                        // Response is stale; go straight to the new target
                        rom_addr_d = redirect_pc;
                    end else begin
                        // Request must stay stable until the ROM answers it
                        state_d = S_DRAIN;
                    end
                end else if (ack_fire) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_next;
                    if (count_after < CNT_W'(DEPTH)) begin
                        rom_addr_d = pc_next;
                    end else begin
                        rom_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                end
                if (ack_fire) begin
                    rom_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                rom_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Queue pointer and occupancy bookkeeping
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are only visible through a valid head
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            data_mem_q[tail_q] <= rom_data;
            pc_mem_q[tail_q]   <= rom_addr_q;
        end
    end

endmodule
